acc_tile_drain: RTL and testbench

Transmit side of the dequantize stream. Accepts one complete MAT_SIZE×MAT_SIZE integer accumulator tile per handshake from the systolic-array accumulator bank. Streams it row-major as LANES_NUM-lane beats on a valid/ready master port that connects directly to the dequantize input (dq_s_*) of the QDQ controller. Two tile banks (ping-pong) let the array deposit tile N+1 while tile N drains, sustaining one beat per cycle with no bubble between tiles.

---
 rtl/qgemm_pkg.sv | 41 ++++
 rtl/acc_tile_bank.sv | 48 ++++
 rtl/acc_tile_drain.sv | 127 ++++++++++++
 tb/tb_acc_tile_drain.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qgemm_pkg.sv
// Shared definitions for the quantized GEMM datapath: size derivations,
// a constant-safe clog2 and a generic sign-extension helper.
package qgemm_pkg;

  // Debug-visible drain state: IDLE when no bank holds a tile, STREAM otherwise.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } drain_state_t;

  // Widest element the sign-extension helper handles.
  localparam int EXT_W = 64;

  function automatic int clog2(input int value);
    int res;
    int x;
    res = 0;
    x   = value - 1;
    while (x > 0) begin
      res = res + 1;
      x   = x >> 1;
    end
    return res;
  endfunction

  function automatic int elems_of(input int mat_size);
    return mat_size * mat_size;
  endfunction

  function automatic int beats_of(input int mat_size, input int lanes_num);
    return (mat_size * mat_size) / lanes_num;
  endfunction

  // Sign-extend the low 'width' bits of 'value' to EXT_W bits.
  function automatic logic [EXT_W-1:0] sext(input logic [EXT_W-1:0] value, input int width);
    logic signed [EXT_W-1:0] tmp;
    tmp = $signed(value << (EXT_W - width));
    return $unsigned(tmp >>> (EXT_W - width));
  endfunction

endpackage

// File: rtl/acc_tile_bank.sv
// One tile-sized register bank: whole-tile write, beat-indexed lane read
// with sign extension from ACC_W to FP_DATA_W.
module acc_tile_bank
  import qgemm_pkg::*;
#(
  parameter  int MAT_SIZE  = 16,
  parameter  int LANES_NUM = 16,
  parameter  int ACC_W     = 32,
  parameter  int FP_DATA_W = 32,
  localparam int ELEMS     = elems_of(MAT_SIZE),
  localparam int BEATS     = beats_of(MAT_SIZE, LANES_NUM),
  localparam int BW        = (BEATS > 1) ? clog2(BEATS) : 1
) (
  input  logic                           clk,
  input  logic                           rstnn,
  input  logic                           we,
  input  logic [ELEMS*ACC_W-1:0]         wdata,
  input  logic [BW-1:0]                  beat_idx,
  output logic [LANES_NUM*FP_DATA_W-1:0] rdata
);

  localparam int BEAT_BITS = LANES_NUM * ACC_W;

  logic [ELEMS*ACC_W-1:0] mem;
  logic [BEAT_BITS-1:0]   beat_slice;
  logic [EXT_W-1:0]       ext;

  // Capture a whole tile in one cycle; cleared on reset so outputs read zero.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      mem <= '0;
    end else if (we) begin
      mem <= wdata;
    end
  end

  // Select the beat, then widen each lane with sign extension.
  always_comb begin
    rdata      = '0;
    ext        = '0;
    beat_slice = mem[int'(beat_idx)*BEAT_BITS +: BEAT_BITS];
    for (int l = 0; l < LANES_NUM; l++) begin
      ext = sext(EXT_W'(beat_slice[l*ACC_W +: ACC_W]), ACC_W);
      rdata[l*FP_DATA_W +: FP_DATA_W] = ext[FP_DATA_W-1:0];
    end
  end

endmodule

// File: rtl/acc_tile_drain.sv
// Ping-pong tile buffer that drains accumulator tiles row-major as
// LANES_NUM-wide beats toward the dequantize stream.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and once raised valid and its
// payload hold until the transfer. s_ready_o and m_valid_o come only from
// registered occupancy, so neither has a combinational path from the other
// side of the block.
module acc_tile_drain
  import qgemm_pkg::*;
#(
  parameter  int MAT_SIZE  = 16,
  parameter  int LANES_NUM = 16,
  parameter  int ACC_W     = 32,
  parameter  int FP_DATA_W = 32,
  localparam int ELEMS     = elems_of(MAT_SIZE),
  localparam int BEATS     = beats_of(MAT_SIZE, LANES_NUM),
  localparam int BW        = (BEATS > 1) ? clog2(BEATS) : 1
) (
  input  logic                           clk,
  input  logic                           rstnn,
  input  logic                           clear_i,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  input  logic [ELEMS*ACC_W-1:0]         s_tile_i,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [LANES_NUM*FP_DATA_W-1:0] m_data_o,
  output logic                           m_last_o,
  output logic                           busy_o,
  output drain_state_t                   state_o
);

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

  drain_state_t  state;
  logic [1:0]    occ;
  logic [1:0]    occ_nxt;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [BW-1:0] beat_cnt;

  logic          load;
  logic          pop;
  logic          last_pop;
  logic [1:0]    bank_we;
  logic [LANES_NUM*FP_DATA_W-1:0] bank_rdata [2];

  assign s_ready_o = (occ != 2'd2);
  assign m_valid_o = (occ != 2'd0);
  assign busy_o    = (occ != 2'd0);
  assign m_last_o  = m_valid_o & (beat_cnt == BEAT_LAST);
  assign state_o   = state;

  assign load     = s_valid_i & s_ready_o;
  assign pop      = m_valid_o & m_ready_i;
  assign last_pop = pop & (beat_cnt == BEAT_LAST);

  // Occupancy after this edge: a tile in and a tile out cancel.
  always_comb begin
    occ_nxt = occ;
    case ({load, last_pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  // Control FSM: pointers, beat position and occupancy; clear overrides any handshake.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state    <= ST_IDLE;
      occ      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      beat_cnt <= '0;
    end else if (clear_i) begin
      state    <= ST_IDLE;
      occ      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      if (load) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        beat_cnt <= last_pop ? '0 : beat_cnt + 1'b1;
      end
      if (last_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ_nxt;
      case (state)
        ST_IDLE:   if (occ_nxt != 2'd0) state <= ST_STREAM;
        ST_STREAM: if (occ_nxt == 2'd0) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Write strobe per bank; a load discarded by clear must not touch storage.
  always_comb begin
    bank_we    = 2'b00;
    bank_we[0] = load & ~clear_i & ~wr_ptr;
    bank_we[1] = load & ~clear_i &  wr_ptr;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    acc_tile_bank #(
      .MAT_SIZE  (MAT_SIZE),
      .LANES_NUM (LANES_NUM),
      .ACC_W     (ACC_W),
      .FP_DATA_W (FP_DATA_W)
    ) u_bank (
      .clk      (clk),
      .rstnn    (rstnn),
      .we       (bank_we[b]),
      .wdata    (s_tile_i),
      .beat_idx (beat_cnt),
      .rdata    (bank_rdata[b])
    );
  end

  assign m_data_o = rd_ptr ? bank_rdata[1] : bank_rdata[0];

endmodule

// File: tb/tb_acc_tile_drain.sv
// Directed and randomized bench for acc_tile_drain with a flat element-queue
// reference model and a second small instance for the ACC_W=24 extension.
module tb_acc_tile_drain;
  import qgemm_pkg::*;

  localparam int MS  = 16;
  localparam int LN  = 16;
  localparam int AW  = 32;
  localparam int FW  = 32;
  localparam int EL  = MS * MS;
  localparam int DW  = LN * FW;

  localparam int MS2 = 4;
  localparam int LN2 = 4;
  localparam int AW2 = 24;
  localparam int EL2 = MS2 * MS2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rstnn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic               clear_i;
  logic               s_valid_i;
  logic               s_ready_o;
  logic [EL*AW-1:0]   s_tile_i;
  logic               m_valid_o;
  logic               m_ready_i;
  logic [DW-1:0]      m_data_o;
  logic               m_last_o;
  logic               busy_o;
  drain_state_t       dbg_state;

  acc_tile_drain #(.MAT_SIZE(MS), .LANES_NUM(LN), .ACC_W(AW), .FP_DATA_W(FW)) u_dut (
    .clk       (clk),
    .rstnn     (rstnn),
    .clear_i   (clear_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_tile_i  (s_tile_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o),
    .busy_o    (busy_o),
    .state_o   (dbg_state)
  );

  // ---------------- narrow-accumulator DUT ----------------
  logic               clear2;
  logic               s2_valid;
  logic               s2_ready;
  logic [EL2*AW2-1:0] s2_tile;
  logic               m2_valid;
  logic               m2_ready;
  logic [LN2*32-1:0]  m2_data;
  logic               m2_last;
  logic               busy2;
  drain_state_t       dbg_state2;

  acc_tile_drain #(.MAT_SIZE(MS2), .LANES_NUM(LN2), .ACC_W(AW2), .FP_DATA_W(32)) u_dut24 (
    .clk       (clk),
    .rstnn     (rstnn),
    .clear_i   (clear2),
    .s_valid_i (s2_valid),
    .s_ready_o (s2_ready),
    .s_tile_i  (s2_tile),
    .m_valid_o (m2_valid),
    .m_ready_i (m2_ready),
    .m_data_o  (m2_data),
    .m_last_o  (m2_last),
    .busy_o    (busy2),
    .state_o   (dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int            errors = 0;
  int            checks = 0;
  logic [FW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: exp_q holds every element still owed downstream, in order.
  function automatic int model_tiles();
    return (exp_q.size() + EL - 1) / EL;
  endfunction

  function automatic bit model_valid();
    return exp_q.size() > 0;
  endfunction

  function automatic bit model_ready();
    return model_tiles() < 2;
  endfunction

  function automatic bit model_last();
    if (exp_q.size() == 0) return 1'b0;
    return (exp_q.size() - (model_tiles() - 1) * EL) == LN;
  endfunction

  function automatic logic [DW-1:0] model_data();
    logic [DW-1:0] d;
    d = '0;
    for (int l = 0; l < LN; l++) d[l*FW +: FW] = exp_q[l];
    return d;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, DW'(m_valid_o), DW'(model_valid()));
    chk({tag, "_ready"}, DW'(s_ready_o), DW'(model_ready()));
    chk({tag, "_busy"},  DW'(busy_o),    DW'(model_valid()));
    chk({tag, "_last"},  DW'(m_last_o),  DW'(model_last()));
    if (model_valid()) chk({tag, "_data"}, m_data_o, model_data());
  endtask

  // ---------------- driver ----------------
  // One clock: check at the falling edge, drive, then apply the edge to the model.
  task automatic step(input string tag, input bit sv, input logic [EL*AW-1:0] tile,
                      input bit rdy, input bit clr, output bit acc);
    bit ev;
    bit er;
    logic signed [AW-1:0] el;
    check_outputs(tag);
    ev        = model_valid();
    er        = model_ready();
    s_valid_i = sv;
    s_tile_i  = tile;
    m_ready_i = rdy;
    clear_i   = clr;
    @(posedge clk);
    acc = sv & er & ~clr;
    if (clr) begin
      exp_q.delete();
    end else begin
      if (ev && rdy) repeat (LN) void'(exp_q.pop_front());
      if (acc) begin
        for (int e = 0; e < EL; e++) begin
          el = tile[e*AW +: AW];
          exp_q.push_back(FW'(el));
        end
      end
    end
    @(negedge clk);
    s_valid_i = 1'b0;
    clear_i   = 1'b0;
  endtask

  function automatic logic [EL*AW-1:0] ramp_tile(input int off);
    logic [EL*AW-1:0] t;
    for (int e = 0; e < EL; e++) t[e*AW +: AW] = AW'(e + off);
    return t;
  endfunction

  function automatic logic [EL*AW-1:0] rand_tile();
    logic [EL*AW-1:0] t;
    for (int e = 0; e < EL; e++) t[e*AW +: AW] = AW'($urandom);
    return t;
  endfunction

  // ---------------- stimulus ----------------
  logic [EL*AW-1:0] tiles [3];
  logic [EL*AW-1:0] cur_tile;
  logic [EL*AW-1:0] t_a;
  logic [FW-1:0]    lane_v;
  bit               acc;
  int               nxt;
  int               run;
  int               max_run;
  int               acc_cyc [3];

  initial begin
    rstnn     = 1'b0;
    clear_i   = 1'b0;
    s_valid_i = 1'b0;
    s_tile_i  = '0;
    m_ready_i = 1'b0;
    clear2    = 1'b0;
    s2_valid  = 1'b0;
    s2_tile   = '0;
    m2_ready  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_valid", DW'(m_valid_o), DW'(1'b0));
    chk("rst_ready", DW'(s_ready_o), DW'(1'b1));
    chk("rst_busy",  DW'(busy_o),    DW'(1'b0));
    chk("rst_last",  DW'(m_last_o),  DW'(1'b0));
    chk("rst_data",  m_data_o,       DW'(0));
    chk("rst_state", DW'(dbg_state), DW'(ST_IDLE));
    rstnn = 1'b1;
    @(negedge clk);

    // 24-bit accumulators sign-extend into 32-bit lanes
    for (int e = 0; e < EL2; e++) s2_tile[e*AW2 +: AW2] = AW2'(e);
    s2_tile[0 +: AW2]   = 24'h800000;
    s2_tile[AW2 +: AW2] = 24'h7FFFFF;
    chk("w24_ready", DW'(s2_ready), DW'(1'b1));
    s2_valid = 1'b1;
    @(negedge clk);
    s2_valid = 1'b0;
    chk("w24_valid", DW'(m2_valid), DW'(1'b1));
    chk("w24_neg",   DW'(m2_data[31:0]),  DW'(32'hFF800000));
    chk("w24_pos",   DW'(m2_data[63:32]), DW'(32'h007FFFFF));
    chk("w24_small", DW'(m2_data[95:64]), DW'(32'h00000002));
    m2_ready = 1'b1;
    repeat (MS2 * MS2 / LN2) @(negedge clk);
    chk("w24_drained", DW'(m2_valid), DW'(1'b0));
    m2_ready = 1'b0;

    // Single tile with element e = e-128, downstream always ready
    step("t1_acc", 1'b1, ramp_tile(-128), 1'b1, 1'b0, acc);
    chk("t1_accepted", DW'(acc), DW'(1'b1));
    chk("t1_first_valid", DW'(m_valid_o), DW'(1'b1));
    chk("t1_b0l0", DW'(m_data_o[0 +: FW]), DW'(32'hFFFFFF80));
    for (int b = 0; b < EL / LN - 1; b++) step("t1", 1'b0, '0, 1'b1, 1'b0, acc);
    chk("t1_b15l15", DW'(m_data_o[(LN-1)*FW +: FW]), DW'(32'h0000007F));
    chk("t1_last", DW'(m_last_o), DW'(1'b1));
    step("t1_end", 1'b0, '0, 1'b1, 1'b0, acc);
    chk("t1_idle_valid", DW'(m_valid_o), DW'(1'b0));
    chk("t1_idle_ready", DW'(s_ready_o), DW'(1'b1));

    // Three tiles back-to-back; third waits for a free bank
    for (int i = 0; i < 3; i++) tiles[i] = rand_tile();
    nxt = 0; run = 0; max_run = 0;
    for (int cyc = 0; cyc < 200 && (nxt < 3 || exp_q.size() > 0); cyc++) begin
      if (m_valid_o) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (nxt < 3) cur_tile = tiles[nxt]; else cur_tile = '0;
      step("b2b", nxt < 3, cur_tile, 1'b1, 1'b0, acc);
      if (acc) begin
        acc_cyc[nxt] = cyc;
        nxt++;
      end
    end
    chk("b2b_all_accepted", DW'(nxt), DW'(3));
    chk("b2b_drained", DW'(exp_q.size()), DW'(0));
    chk("b2b_second_imm", DW'(acc_cyc[1]), DW'(1));
    chk("b2b_third_wait", DW'(acc_cyc[2]), DW'(1 + EL / LN));
    chk("b2b_contig", DW'(max_run), DW'(3 * EL / LN));

    // Random ready and offer pattern over 10 tiles
    nxt = 0;
    cur_tile = rand_tile();
    for (int cyc = 0; cyc < 4000 && (nxt < 10 || exp_q.size() > 0); cyc++) begin
      step("rnd", (nxt < 10) && ($urandom_range(0, 3) != 0), cur_tile,
           1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) begin
        nxt++;
        cur_tile = rand_tile();
      end
    end
    chk("rnd_all_accepted", DW'(nxt), DW'(10));
    chk("rnd_drained", DW'(exp_q.size()), DW'(0));

    // Clear at beat 7 of the first tile with a second tile buffered
    step("clr_a", 1'b1, rand_tile(), 1'b0, 1'b0, acc);
    step("clr_b", 1'b1, rand_tile(), 1'b0, 1'b0, acc);
    for (int b = 0; b < 7; b++) step("clr_pre", 1'b0, '0, 1'b1, 1'b0, acc);
    chk("clr_buffered_ready", DW'(s_ready_o), DW'(1'b0));
    step("clr_hit", 1'b1, rand_tile(), 1'b1, 1'b1, acc);
    chk("clr_valid", DW'(m_valid_o), DW'(1'b0));
    chk("clr_busy",  DW'(busy_o),    DW'(1'b0));
    chk("clr_ready", DW'(s_ready_o), DW'(1'b1));
    t_a = rand_tile();
    step("clr_new", 1'b1, t_a, 1'b1, 1'b0, acc);
    lane_v = t_a[0 +: AW];
    chk("clr_new_b0", DW'(m_data_o[0 +: FW]), DW'(lane_v));
    for (int b = 0; b < EL / LN; b++) step("clr_drain", 1'b0, '0, 1'b1, 1'b0, acc);

    // Asynchronous reset in the middle of a tile
    step("ar_acc", 1'b1, rand_tile(), 1'b1, 1'b0, acc);
    for (int b = 0; b < 3; b++) step("ar_pre", 1'b0, '0, 1'b1, 1'b0, acc);
    #2 rstnn = 1'b0;
    #1;
    chk("ar_valid", DW'(m_valid_o), DW'(1'b0));
    chk("ar_ready", DW'(s_ready_o), DW'(1'b1));
    chk("ar_busy",  DW'(busy_o),    DW'(1'b0));
    chk("ar_last",  DW'(m_last_o),  DW'(1'b0));
    chk("ar_data",  m_data_o,       DW'(0));
    exp_q.delete();
    @(negedge clk);
    rstnn = 1'b1;
    @(negedge clk);
    t_a = rand_tile();
    step("ar_new", 1'b1, t_a, 1'b1, 1'b0, acc);
    lane_v = t_a[0 +: AW];
    chk("ar_new_valid", DW'(m_valid_o), DW'(1'b1));
    chk("ar_new_b0", DW'(m_data_o[0 +: FW]), DW'(lane_v));
    for (int b = 0; b < EL / LN; b++) step("ar_drain", 1'b0, '0, 1'b1, 1'b0, acc);
    check_outputs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
